// File: rtl/pipe_hazard_ctrl_pkg.sv
// rtl/pipe_hazard_ctrl_pkg.sv - shared encodings for the pipeline hazard controller
package pipe_hazard_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  typedef enum logic [0:0] {
    HZ_IDLE = 1'b0,
    HZ_WAIT = 1'b1
  } hz_state_t;

endpackage

// File: rtl/pipe_fwd_unit.sv
// rtl/pipe_fwd_unit.sv - combinational EX operand forwarding select for one source register
module pipe_fwd_unit
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RAW = 5
) (
  input  logic [RAW-1:0] ex_rs,
  input  logic           mem_valid,
  input  logic           mem_regwrite,
  input  logic [RAW-1:0] mem_rd,
  input  logic           wb_valid,
  input  logic           wb_regwrite,
  input  logic [RAW-1:0] wb_rd,
  output logic [1:0]     fwd
);

  // The younger producer (EX/MEM) wins; x0 is hardwired zero and never forwarded.
  always_comb begin
    fwd = FWD_RF;
    if (mem_valid && mem_regwrite && (mem_rd != '0) && (mem_rd == ex_rs))
      fwd = FWD_MEM;
    else if (wb_valid && wb_regwrite && (wb_rd != '0) && (wb_rd == ex_rs))
      fwd = FWD_WB;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard controller; PIPE_PERF_CNT_EN adds stall/flush counters
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int RAW     = 5,
  parameter int MEM_LAT = 1,
  parameter int CNTW    = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [RAW-1:0] id_rs1,
  input  logic [RAW-1:0] id_rs2,
  input  logic           id_use_rs1,
  input  logic           id_use_rs2,
  input  logic           ex_valid,
  input  logic [RAW-1:0] ex_rs1,
  input  logic [RAW-1:0] ex_rs2,
  input  logic [RAW-1:0] ex_rd,
  input  logic           ex_regwrite,
  input  logic           ex_is_load,
  input  logic           ex_redirect,
  input  logic           mem_valid,
  input  logic [RAW-1:0] mem_rd,
  input  logic           mem_regwrite,
  input  logic           mem_is_mem,
  input  logic           wb_valid,
  input  logic [RAW-1:0] wb_rd,
  input  logic           wb_regwrite,
  output logic [1:0]     fwd_a,
  output logic [1:0]     fwd_b,
  output logic           pc_en,
  output logic           if_id_en,
  output logic           id_ex_en,
  output logic           ex_mem_en,
  output logic           mem_wb_en,
  output logic           if_id_flush,
  output logic           id_ex_flush,
  output logic           mem_wb_bubble,
  output logic           mem_busy,
  output logic [31:0]    perf_stall,
  output logic [31:0]    perf_flush
);

  localparam bit              HAS_WAIT = (MEM_LAT != 0);
  localparam logic [CNTW-1:0] LAT_M1   = CNTW'((MEM_LAT > 0) ? MEM_LAT - 1 : 0);

  hz_state_t       state;
  logic [CNTW-1:0] cnt;
  logic            busy;
  logic            lu;
  logic            mem_op;
  logic [1:0]      fwd_a_raw;
  logic [1:0]      fwd_b_raw;

  pipe_fwd_unit #(.RAW(RAW)) u_fwd_a (
    .ex_rs        (ex_rs1),
    .mem_valid    (mem_valid),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .fwd          (fwd_a_raw)
  );

  pipe_fwd_unit #(.RAW(RAW)) u_fwd_b (
    .ex_rs        (ex_rs2),
    .mem_valid    (mem_valid),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_valid     (wb_valid),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .fwd          (fwd_b_raw)
  );

  assign mem_op = mem_valid & mem_is_mem;
  assign lu = ex_valid & ex_is_load & (ex_rd != '0) &
              ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  // Busy starts in the IDLE cycle the op is seen, so the freeze lasts exactly MEM_LAT cycles.
  assign busy = (state == HZ_IDLE) ? (mem_op && HAS_WAIT) : (cnt != '0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= HZ_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        HZ_IDLE: begin
          if (mem_op && HAS_WAIT) begin
            state <= HZ_WAIT;
            cnt   <= LAT_M1;
          end
        end
        HZ_WAIT: begin
          if (cnt != '0) cnt <= cnt - CNTW'(1);
          else           state <= HZ_IDLE;
        end
        default: state <= HZ_IDLE;
      endcase
    end
  end

  // A redirect or load-use arriving while busy stays in EX and is acted on at release.
  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_ex_en      = 1'b1;
    ex_mem_en     = 1'b1;
    mem_wb_en     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    mem_wb_bubble = 1'b0;
    mem_busy      = 1'b0;
    fwd_a         = fwd_a_raw;
    fwd_b         = fwd_b_raw;
    if (!reset) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      mem_wb_bubble = 1'b1;
      fwd_a         = FWD_RF;
      fwd_b         = FWD_RF;
    end else if (busy) begin
      mem_busy      = 1'b1;
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_en      = 1'b0;
      ex_mem_en     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (ex_redirect) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end else if (lu) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_ex_flush   = 1'b1;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_q;
  logic [31:0] flush_q;
  logic        redirect_flush;

  assign redirect_flush = reset & ~busy & ex_redirect;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en)         stall_q <= stall_q + 32'd1;
      if (redirect_flush) flush_q <= flush_q + 32'd1;
    end
  end

  assign perf_stall = stall_q;
  assign perf_flush = flush_q;
`else
  assign perf_stall = '0;
  assign perf_flush = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - directed self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
  import pipe_hazard_ctrl_pkg::*;

  // ctl vector order: pc, if_id, id_ex, ex_mem, mem_wb, if_id_flush, id_ex_flush, bubble, busy
  localparam logic [8:0] CTL_RESET = 9'b111111110;
  localparam logic [8:0] CTL_IDLE  = 9'b111110000;
  localparam logic [8:0] CTL_LU    = 9'b001110100;
  localparam logic [8:0] CTL_REDIR = 9'b111111100;
  localparam logic [8:0] CTL_BUSY  = 9'b000010011;
`ifdef PIPE_PERF_CNT_EN
  localparam logic [31:0] EXP_STALL = 32'd4;
  localparam logic [31:0] EXP_FLUSH = 32'd1;
`else
  localparam logic [31:0] EXP_STALL = 32'd0;
  localparam logic [31:0] EXP_FLUSH = 32'd0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic id_use_rs1, id_use_rs2, ex_valid, ex_regwrite, ex_is_load, ex_redirect;
  logic mem_valid, mem_regwrite, mem_is_mem, wb_valid, wb_regwrite;

  logic [1:0]  a_fwd_a, a_fwd_b, b_fwd_a, b_fwd_b;
  logic        a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en;
  logic        a_if_id_flush, a_id_ex_flush, a_mem_wb_bubble, a_mem_busy;
  logic        b_pc_en, b_if_id_en, b_id_ex_en, b_ex_mem_en, b_mem_wb_en;
  logic        b_if_id_flush, b_id_ex_flush, b_mem_wb_bubble, b_mem_busy;
  logic [31:0] a_perf_stall, a_perf_flush, b_perf_stall, b_perf_flush;
  logic [8:0]  a_ctl;

  int checks = 0;
  int errors = 0;

  assign a_ctl = {a_pc_en, a_if_id_en, a_id_ex_en, a_ex_mem_en, a_mem_wb_en,
                  a_if_id_flush, a_id_ex_flush, a_mem_wb_bubble, a_mem_busy};

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.RAW(5), .MEM_LAT(3), .CNTW(3)) dut_a (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_valid(mem_valid),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_is_mem(mem_is_mem),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a(a_fwd_a), .fwd_b(a_fwd_b), .pc_en(a_pc_en), .if_id_en(a_if_id_en),
    .id_ex_en(a_id_ex_en), .ex_mem_en(a_ex_mem_en), .mem_wb_en(a_mem_wb_en),
    .if_id_flush(a_if_id_flush), .id_ex_flush(a_id_ex_flush),
    .mem_wb_bubble(a_mem_wb_bubble), .mem_busy(a_mem_busy),
    .perf_stall(a_perf_stall), .perf_flush(a_perf_flush)
  );

  pipe_hazard_ctrl #(.RAW(5), .MEM_LAT(2), .CNTW(3)) dut_b (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
    .ex_is_load(ex_is_load), .ex_redirect(ex_redirect), .mem_valid(mem_valid),
    .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .mem_is_mem(mem_is_mem),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_regwrite(wb_regwrite),
    .fwd_a(b_fwd_a), .fwd_b(b_fwd_b), .pc_en(b_pc_en), .if_id_en(b_if_id_en),
    .id_ex_en(b_id_ex_en), .ex_mem_en(b_ex_mem_en), .mem_wb_en(b_mem_wb_en),
    .if_id_flush(b_if_id_flush), .id_ex_flush(b_id_ex_flush),
    .mem_wb_bubble(b_mem_wb_bubble), .mem_busy(b_mem_busy),
    .perf_stall(b_perf_stall), .perf_flush(b_perf_flush)
  );

  task clear_inputs;
    id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0;
    ex_valid = 0; ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0;
    ex_regwrite = 0; ex_is_load = 0; ex_redirect = 0;
    mem_valid = 0; mem_rd = 0; mem_regwrite = 0; mem_is_mem = 0;
    wb_valid = 0; wb_rd = 0; wb_regwrite = 0;
  endtask

  task do_reset;
    reset = 0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 reset = 1;
    #1;
  endtask

  task test_reset;
    reset = 0;
    clear_inputs();
    mem_valid = 1; mem_regwrite = 1; mem_rd = 5; mem_is_mem = 1; ex_rs1 = 5;
    @(posedge clk); #2;
    checks++;
    if (a_ctl !== CTL_RESET) begin
      $display("FAIL reset_ctl: got %b expected %b", a_ctl, CTL_RESET); errors++;
    end
    checks++;
    if (a_fwd_a !== FWD_RF) begin
      $display("FAIL reset_fwd_a: got %b expected %b", a_fwd_a, FWD_RF); errors++;
    end
    do_reset();
    #1;
    checks++;
    if (a_ctl !== CTL_IDLE) begin
      $display("FAIL reset_release_idle: got %b expected %b", a_ctl, CTL_IDLE); errors++;
    end
    checks++;
    if (b_perf_stall !== 32'd0 || b_perf_flush !== 32'd0) begin
      $display("FAIL reset_perf: got %0d/%0d expected 0/0", b_perf_stall, b_perf_flush); errors++;
    end
  endtask

  task test_forwarding;
    do_reset();
    mem_valid = 1; mem_regwrite = 1; mem_rd = 5;
    wb_valid = 1; wb_regwrite = 1; wb_rd = 5;
    ex_valid = 1; ex_rs1 = 5; ex_rs2 = 0;
    #2;
    checks++;
    if (a_fwd_a !== FWD_MEM) begin
      $display("FAIL fwd_mem_wins: got %b expected %b", a_fwd_a, FWD_MEM); errors++;
    end
    checks++;
    if (a_fwd_b !== FWD_RF) begin
      $display("FAIL fwd_x0_b: got %b expected %b", a_fwd_b, FWD_RF); errors++;
    end
    mem_regwrite = 0; ex_rs2 = 5;
    #2;
    checks++;
    if (a_fwd_a !== FWD_WB || a_fwd_b !== FWD_WB) begin
      $display("FAIL fwd_wb: got %b/%b expected %b/%b", a_fwd_a, a_fwd_b, FWD_WB, FWD_WB); errors++;
    end
    mem_regwrite = 1; mem_rd = 0; wb_rd = 0; ex_rs1 = 0; ex_rs2 = 0;
    #2;
    checks++;
    if (a_fwd_a !== FWD_RF || a_fwd_b !== FWD_RF) begin
      $display("FAIL fwd_x0_never: got %b/%b expected 00/00", a_fwd_a, a_fwd_b); errors++;
    end
    mem_rd = 9; wb_rd = 9; mem_valid = 0; ex_rs2 = 9;
    #2;
    checks++;
    if (a_fwd_b !== FWD_WB) begin
      $display("FAIL fwd_mem_invalid: got %b expected %b", a_fwd_b, FWD_WB); errors++;
    end
  endtask

  task test_load_use;
    do_reset();
    ex_valid = 1; ex_is_load = 1; ex_regwrite = 1; ex_rd = 6;
    id_use_rs2 = 1; id_rs2 = 6;
    #2;
    checks++;
    if (a_ctl !== CTL_LU) begin
      $display("FAIL lu_stall: got %b expected %b", a_ctl, CTL_LU); errors++;
    end
    id_use_rs2 = 0;
    #2;
    checks++;
    if (a_ctl !== CTL_IDLE) begin
      $display("FAIL lu_unused_src: got %b expected %b", a_ctl, CTL_IDLE); errors++;
    end
    id_use_rs2 = 1; ex_rd = 0; id_rs2 = 0;
    #2;
    checks++;
    if (a_ctl !== CTL_IDLE) begin
      $display("FAIL lu_x0: got %b expected %b", a_ctl, CTL_IDLE); errors++;
    end
    // Load has moved on to MEM/WB; the dependent add is now in EX.
    @(posedge clk); #1;
    clear_inputs();
    ex_valid = 1; ex_rs2 = 6; wb_valid = 1; wb_regwrite = 1; wb_rd = 6;
    id_use_rs2 = 1; id_rs2 = 6;
    #2;
    checks++;
    if (a_fwd_b !== FWD_WB || a_ctl !== CTL_IDLE) begin
      $display("FAIL lu_followup: got fwd_b=%b ctl=%b expected %b %b", a_fwd_b, a_ctl, FWD_WB, CTL_IDLE); errors++;
    end
  endtask

  task test_redirect;
    do_reset();
    ex_valid = 1; ex_is_load = 1; ex_rd = 6; ex_redirect = 1;
    id_use_rs1 = 1; id_rs1 = 6;
    #2;
    checks++;
    if (a_ctl !== CTL_REDIR) begin
      $display("FAIL redirect_over_lu: got %b expected %b", a_ctl, CTL_REDIR); errors++;
    end
  endtask

  task test_mem_wait;
    logic [8:0] exp;
    do_reset();
    mem_valid = 1; mem_is_mem = 1; ex_valid = 1; ex_redirect = 1;
    #2;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(posedge clk); #3;
      end
      exp = (c < 3) ? CTL_BUSY : CTL_REDIR;
      checks++;
      if (a_ctl !== exp) begin
        $display("FAIL mem_wait_cycle%0d: got %b expected %b", c, a_ctl, exp); errors++;
      end
    end
    @(posedge clk); #1;
    clear_inputs();
    #2;
    checks++;
    if (a_ctl !== CTL_IDLE) begin
      $display("FAIL mem_wait_after: got %b expected %b", a_ctl, CTL_IDLE); errors++;
    end
  endtask

  task test_reset_mid_wait;
    do_reset();
    mem_valid = 1; mem_is_mem = 1;
    @(posedge clk); #3;
    checks++;
    if (a_mem_busy !== 1'b1) begin
      $display("FAIL midwait_busy: got %b expected 1", a_mem_busy); errors++;
    end
    @(posedge clk); #1;
    reset = 0;
    clear_inputs();
    #2;
    checks++;
    if (a_ctl !== CTL_RESET) begin
      $display("FAIL midwait_forced: got %b expected %b", a_ctl, CTL_RESET); errors++;
    end
    @(posedge clk); #1;
    reset = 1;
    #2;
    checks++;
    if (a_ctl !== CTL_IDLE) begin
      $display("FAIL midwait_release: got %b expected %b", a_ctl, CTL_IDLE); errors++;
    end
    @(posedge clk); #2;
    checks++;
    if (a_ctl !== CTL_IDLE) begin
      $display("FAIL midwait_residual: got %b expected %b", a_ctl, CTL_IDLE); errors++;
    end
  endtask

  task test_perf;
    do_reset();
    for (int n = 0; n < 2; n++) begin
      mem_valid = 1; mem_is_mem = 1; mem_regwrite = 1; mem_rd = 8;
      repeat (3) @(posedge clk);
      #1 clear_inputs();
      @(posedge clk); #1;
    end
    ex_valid = 1; ex_redirect = 1;
    @(posedge clk); #1;
    clear_inputs();
    @(posedge clk); #2;
    checks++;
    if (b_perf_stall !== EXP_STALL) begin
      $display("FAIL perf_stall: got %0d expected %0d", b_perf_stall, EXP_STALL); errors++;
    end
    checks++;
    if (b_perf_flush !== EXP_FLUSH) begin
      $display("FAIL perf_flush: got %0d expected %0d", b_perf_flush, EXP_FLUSH); errors++;
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_reset_mid_wait();
    test_perf();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
